// File: rtl/wb_stage_writeback.sv
// ---------------------------------------------------------------------------
// wb_stage_writeback
//   Registered MEM/WB writeback stage. Formats load data (byte/half/word,
//   signed/unsigned, little-endian lane by byte offset), picks the
//   register-file write value (link address, load data or ALU result) and
//   registers it together with the write enable and destination.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_stall, i_flush      hold contents / load a bubble (flush wins)
//   i_valid               incoming instruction is valid
//   i_reg_write           instruction writes the register file
//   i_mem_to_reg          write value comes from the load path
//   i_jal, i_link_ra      write link address / force destination to all-ones
//   i_load_size           00 byte, 01 half, 1x word
//   i_load_unsigned       zero-extend instead of sign-extend
//   i_byte_off            address[1:0] of the load
//   i_mem_data            raw data-memory read word (only [31:0] used)
//   i_alu_result, i_pc    ALU result, instruction PC
//   i_rd_addr             destination register
//   o_valid, o_reg_write  stage valid, register-file write enable
//   o_rd_addr, o_wb_data  register-file write address and data
// ---------------------------------------------------------------------------
module wb_stage_writeback #(
    parameter int NBITS       = 32,
    parameter int NB_REG      = 5,
    parameter int LINK_OFFSET = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic              i_reg_write,
    input  logic              i_mem_to_reg,
    input  logic              i_jal,
    input  logic              i_link_ra,
    input  logic [1:0]        i_load_size,
    input  logic              i_load_unsigned,
    input  logic [1:0]        i_byte_off,
    input  logic [NBITS-1:0]  i_mem_data,
    input  logic [NBITS-1:0]  i_alu_result,
    input  logic [NBITS-1:0]  i_pc,
    input  logic [NB_REG-1:0] i_rd_addr,
    output logic              o_valid,
    output logic              o_reg_write,
    output logic [NB_REG-1:0] o_rd_addr,
    output logic [NBITS-1:0]  o_wb_data
);

    localparam logic [NBITS-1:0] LINK_OFF = NBITS'(LINK_OFFSET);

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic [NB_REG-1:0] rd_addr_q, rd_addr_d;
    logic [NBITS-1:0]  wb_data_q, wb_data_d;

    logic [31:0]       word;
    logic [7:0]        lane8;
    logic [15:0]       lane16;
    logic [NBITS-1:0]  load_val;
    logic [NBITS-1:0]  wdata;
    logic [NB_REG-1:0] dest;

    // Load formatting: only the low 32 bits of the memory word carry lanes.
    always_comb begin
        word   = i_mem_data[31:0];
        lane8  = word[{i_byte_off, 3'b000} +: 8];
        // Half loads ignore off[0]; misalignment is handled elsewhere.
        lane16 = i_byte_off[1] ? word[31:16] : word[15:0];
        case (i_load_size)
            2'b00:   load_val = i_load_unsigned ? NBITS'(lane8)
                                                : NBITS'($signed(lane8));
            2'b01:   load_val = i_load_unsigned ? NBITS'(lane16)
                                                : NBITS'($signed(lane16));
            default: load_val = i_load_unsigned ? NBITS'(word)
                                                : NBITS'($signed(word));
        endcase
    end

    always_comb begin
        dest = (i_jal && i_link_ra) ? '1 : i_rd_addr;
        if (i_jal)
            wdata = i_pc + LINK_OFF;   // wraps silently
        else if (i_mem_to_reg)
            wdata = load_val;
        else
            wdata = i_alu_result;
    end

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_addr_d   = rd_addr_q;
        wb_data_d   = wb_data_q;
        if (i_flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            rd_addr_d   = '0;
            wb_data_d   = '0;
        end else if (!i_stall) begin
            valid_d     = i_valid;
            // $0 is hard-wired: keep the address visible but never write it.
            reg_write_d = i_valid && i_reg_write && (dest != '0);
            rd_addr_d   = dest;
            wb_data_d   = wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_addr_q   <= rd_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_reg_write = reg_write_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_wb_data   = wb_data_q;

endmodule

// File: tb/tb_wb_stage_writeback.sv
module tb_wb_stage_writeback;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall, i_flush, i_valid, i_reg_write, i_mem_to_reg;
    logic        i_jal, i_link_ra, i_load_unsigned;
    logic [1:0]  i_load_size, i_byte_off;
    logic [31:0] i_mem_data, i_alu_result, i_pc;
    logic [4:0]  i_rd_addr;
    logic        o_valid, o_reg_write;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_wb_data;

    wb_stage_writeback #(.NBITS(32), .NB_REG(5), .LINK_OFFSET(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
        .i_jal(i_jal), .i_link_ra(i_link_ra), .i_load_size(i_load_size),
        .i_load_unsigned(i_load_unsigned), .i_byte_off(i_byte_off),
        .i_mem_data(i_mem_data), .i_alu_result(i_alu_result), .i_pc(i_pc),
        .i_rd_addr(i_rd_addr), .o_valid(o_valid), .o_reg_write(o_reg_write),
        .o_rd_addr(o_rd_addr), .o_wb_data(o_wb_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic void check(string name, exp_t act, exp_t e);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got v=%0b rw=%0b rd=%0d data=%08h, expected v=%0b rw=%0b rd=%0d data=%08h",
                     name, act.v, act.rw, act.rd, act.d, e.v, e.rw, e.rd, e.d);
        end
    endfunction

    function automatic exp_t outs();
        return '{v: o_valid, rw: o_reg_write, rd: o_rd_addr, d: o_wb_data};
    endfunction

    // Monitor: one expectation per issued cycle, compared just after the edge.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0)
                check(name_q.pop_front(), outs(), exp_q.pop_front());
        end
    end

    task automatic defaults();
        i_stall = 0; i_flush = 0; i_valid = 1; i_reg_write = 1; i_mem_to_reg = 0;
        i_jal = 0; i_link_ra = 0; i_load_size = 2'b10; i_load_unsigned = 0;
        i_byte_off = 0; i_mem_data = 32'h80FF_7F81; i_alu_result = 0;
        i_pc = 0; i_rd_addr = 0;
    endtask

    // Issue the currently driven inputs for one edge with the expected result.
    task automatic step(string name, logic v, logic rw, logic [4:0] rd, logic [31:0] d);
        exp_q.push_back('{v: v, rw: rw, rd: rd, d: d});
        name_q.push_back(name);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic load(string name, logic [1:0] sz, logic uns, logic [1:0] off, logic [31:0] d);
        defaults();
        i_mem_to_reg = 1; i_rd_addr = 5'd2; i_alu_result = 32'hDEAD_BEEF;
        i_load_size = sz; i_load_unsigned = uns; i_byte_off = off;
        step(name, 1, 1, 5'd2, d);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        defaults();
        i_rst_n = 0;
        // Reset held with toggling inputs
        for (int k = 0; k < 3; k++) begin
            i_rd_addr = 5'($urandom); i_alu_result = $urandom; i_valid = 1'($urandom);
            i_flush = 1'($urandom); i_stall = 1'($urandom);
            @(negedge i_clk);
            check("reset_hold", outs(), '0);
        end
        defaults();
        i_rst_n = 1;

        i_rd_addr = 5'd5; i_alu_result = 32'h0000_1234;
        step("alu_first", 1, 1, 5'd5, 32'h0000_1234);

        load("lb_off0",   2'b00, 0, 2'd0, 32'hFFFF_FF81);
        load("lbu_off1",  2'b00, 1, 2'd1, 32'h0000_007F);
        load("lb_off3",   2'b00, 0, 2'd3, 32'hFFFF_FF80);
        load("lh_off2",   2'b01, 0, 2'd2, 32'hFFFF_80FF);
        load("lhu_off3",  2'b01, 1, 2'd3, 32'h0000_80FF);
        load("lh_off1",   2'b01, 0, 2'd1, 32'h0000_7F81);
        load("lw",        2'b10, 0, 2'd2, 32'h80FF_7F81);
        load("lw_sz3",    2'b11, 1, 2'd1, 32'h80FF_7F81);

        defaults(); i_jal = 1; i_link_ra = 1; i_pc = 32'h0040_0010; i_rd_addr = 5'd7;
        step("jal_ra", 1, 1, 5'd31, 32'h0040_0018);
        i_pc = 32'hFFFF_FFFC;
        step("jal_wrap", 1, 1, 5'd31, 32'h0000_0004);
        i_link_ra = 0; i_mem_to_reg = 1; i_pc = 32'h0000_1000;
        step("jalr_over_load", 1, 1, 5'd7, 32'h0000_1008);

        defaults(); i_rd_addr = 5'd9; i_alu_result = 32'hA;
        step("pre_stall", 1, 1, 5'd9, 32'hA);
        for (int k = 0; k < 3; k++) begin
            i_stall = 1; i_rd_addr = 5'(k + 12); i_alu_result = 32'(k + 100); i_valid = k[0];
            step("stall_hold", 1, 1, 5'd9, 32'hA);
        end
        i_stall = 1; i_flush = 1;
        step("stall_flush", 0, 0, 5'd0, 32'h0);
        defaults(); i_rd_addr = 5'd4; i_alu_result = 32'h55;
        step("post_flush", 1, 1, 5'd4, 32'h55);
        i_flush = 1;
        step("flush_only", 0, 0, 5'd0, 32'h0);

        defaults(); i_rd_addr = 5'd0; i_alu_result = 32'h77;
        step("rd_zero", 1, 0, 5'd0, 32'h77);
        i_valid = 0; i_rd_addr = 5'd3; i_alu_result = 32'h99;
        step("invalid", 0, 0, 5'd3, 32'h99);

        // Asynchronous reset between edges while holding data
        defaults(); i_rd_addr = 5'd6; i_alu_result = 32'h66;
        step("pre_async", 1, 1, 5'd6, 32'h66);
        i_stall = 1;
        #2 i_rst_n = 0;
        #1 check("async_rst_immediate", outs(), '0);
        @(posedge i_clk); #1;
        check("async_rst_held", outs(), '0);
        @(negedge i_clk);
        i_rst_n = 1;
        check("after_release", outs(), '0);
        defaults(); i_rd_addr = 5'd8; i_alu_result = 32'h88;
        step("post_async", 1, 1, 5'd8, 32'h88);

        @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage_writeback.md
Name: wb_stage_writeback

Overview:
- Registered MEM/WB writeback stage for the MIPS pipeline.
- Formats load data (byte/half/word, signed/unsigned, by byte offset).
- Selects the register-file write value from: load data, ALU result, or link address (PC + LINK_OFFSET) for JAL/JALR.
- Supports stall (hold) and flush (bubble).
- Its outputs drive the register-file write port and the forwarding unit.

Parameters:
- NBITS, 32, datapath width; multiple of 8, at least 32.
- NB_REG, 5, register address width.
- LINK_OFFSET, 8, value added to PC to form the link address.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_stall  in  1  hold stage register contents.
- i_flush  in  1  load a bubble into the stage.
- i_valid  in  1  incoming instruction is valid.
- i_reg_write  in  1  instruction writes the register file.
- i_mem_to_reg  in  1  write value comes from memory.
- i_jal  in  1  write value is the link address.
- i_link_ra  in  1  force destination to the all-ones register ($31 for NB_REG=5).
- i_load_size  in  2  00 byte, 01 half, 1x word.
- i_load_unsigned  in  1  zero-extend, not sign-extend.
- i_byte_off  in  2  address[1:0] of the load.
- i_mem_data  in  NBITS  raw data-memory read word.
- i_alu_result  in  NBITS  ALU result.
- i_pc  in  NBITS  PC of the instruction.
- i_rd_addr  in  NB_REG  destination register.
- o_valid  out  1  stage holds a valid instruction.
- o_reg_write  out  1  register-file write enable.
- o_rd_addr  out  NB_REG  register-file write address.
- o_wb_data  out  NBITS  register-file write data.

Behaviour:
- Reset: i_rst_n low clears all outputs to 0 immediately, independent of i_clk. The first capture is at the first rising edge after i_rst_n deasserts.
- Latency: 1 cycle. The value computed from inputs at edge N appears on outputs after edge N. No combinational input-to-output paths.
- Per-edge priority:
  - flush: o_valid, o_reg_write, o_rd_addr and o_wb_data are cleared to 0. Flush wins over stall.
  - else stall: all outputs hold their values.
  - else capture: new values are loaded.
- Captured o_valid = i_valid.
- Captured o_reg_write = i_valid & i_reg_write & (dest != 0). Writes to register 0 are suppressed. o_rd_addr still shows dest.
- dest = all-ones when i_jal & i_link_ra; otherwise i_rd_addr.
- Write-data select, priority order:
  - i_jal: link = (i_pc + LINK_OFFSET) mod 2^NBITS. Wrap-around is silent.
  - else i_mem_to_reg: formatted load.
  - else: i_alu_result.
- Load formatting, little-endian lanes within i_mem_data[31:0]:
  - byte: lane i_mem_data[8*off+7 : 8*off].
  - half: off[1]=0 selects [15:0], off[1]=1 selects [31:16]; off[0] is ignored (no misalignment trap here).
  - word: [31:0], off ignored.
- Extension: to NBITS by sign of the selected lane's MSB, or by zeros when i_load_unsigned=1. Word loads extend only when NBITS > 32.
- Bits of i_mem_data above 31 are ignored.
- When i_valid=0, data and address fields are still captured, but o_reg_write=0.
- Reset asserted mid-stall or mid-flush: reset wins, outputs are 0.

Test Plan:
- Reset: hold i_rst_n=0 with arbitrary inputs toggling -> all outputs 0. Release, apply valid ALU op (rd=5, alu=0x0000_1234) -> next cycle o_valid=1, o_reg_write=1, o_rd_addr=5, o_wb_data=0x0000_1234.
- Loads: i_mem_data=0x80FF_7F81, mem_to_reg=1.
  - byte off=0 signed -> 0xFFFF_FF81.
  - byte off=1 unsigned -> 0x0000_007F.
  - half off=2 signed -> 0xFFFF_80FF.
  - half off=3 unsigned -> 0x0000_80FF.
  - word -> 0x80FF_7F81.
- Link:
  - i_jal=1, i_link_ra=1, i_pc=0x0040_0010, rd=7 -> o_rd_addr=31, o_wb_data=0x0040_0018.
  - i_pc=0xFFFF_FFFC -> o_wb_data=0x0000_0004.
  - i_jal=1 and i_mem_to_reg=1 together -> link value wins.
- Stall/flush:
  - Capture rd=9 data=0xA; then stall 3 cycles with changing inputs -> outputs unchanged.
  - Assert stall+flush together -> outputs all 0 after the edge.
  - Deassert both -> new capture next edge.
- Reg-0 and invalid:
  - rd=0, reg_write=1 -> o_reg_write=0, o_wb_data updated.
  - i_valid=0, reg_write=1, rd=3 -> o_valid=0, o_reg_write=0.
- Async reset mid-operation: pulse i_rst_n low between clock edges while the stage holds data -> outputs go to 0 before the next edge and stay 0 until a capture after release.
